// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: 5-stage pipeline stall/flush control with memory-wait tracking, hang trap and saturating event counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic             ID_UsesRT,
  input  logic             EX_MEM_RDEN,
  input  logic [4:0]       EX_RD,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MEM_RDEN,
  input  logic             MEM_MEM_WREN,
  input  logic             mem_ready,
  output logic             PC_WREN,
  output logic             IF_ID_WREN,
  output logic             IF_ID_flush,
  output logic             ID_EX_WREN,
  output logic             ID_EX_flush,
  output logic             EX_MEM_hold,
  output logic             MEM_WB_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic mem_acc, load_use, freeze, advance, timeout_nx;
  always_comb begin
    mem_acc = MEM_MEM_RDEN | MEM_MEM_WREN;
    load_use = EX_MEM_RDEN & (EX_RD != 5'd0) & ((EX_RD == ID_RS) | (ID_UsesRT & (EX_RD == ID_RT)));
    freeze = (state == ERROR) | (state == RUN & mem_acc & !mem_ready) | (state == MEM_WAIT & !mem_ready);
    // A taken branch squashes the dependent instruction, so it overrides the load-use bubble
    advance = !freeze & (EX_BranchTaken | !load_use);
    PC_WREN = advance;
    IF_ID_WREN = advance;
    IF_ID_flush = !freeze & EX_BranchTaken;
    ID_EX_WREN = !freeze;
    ID_EX_flush = !freeze & (EX_BranchTaken | load_use);
    EX_MEM_hold = freeze;
    MEM_WB_flush = freeze;
    state_nx = state;
    wait_nx = wait_cnt;
    timeout_nx = mem_timeout;
    if (state == RUN && mem_acc && !mem_ready) begin
      state_nx = MEM_WAIT;
      wait_nx = WW'(1);
    end else if (state == MEM_WAIT && mem_ready) begin
      state_nx = RUN;
      wait_nx = '0;
    end else if (state == MEM_WAIT && wait_cnt == WW'(MEM_TIMEOUT)) begin
      state_nx = ERROR;
      timeout_nx = 1'b1;
    end else if (state == MEM_WAIT) begin
      wait_nx = wait_cnt + WW'(1);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      wait_cnt <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nx;
      wait_cnt <= wait_nx;
      mem_timeout <= timeout_nx;
      if (!PC_WREN && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (IF_ID_flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule
